snd_dma_frame_cnt: RTL
======================

Name: snd_dma_frame_cnt

Overview:
Parametrised sound-DMA address generator, successor to the fixed 21-bit sound counter in the MCU sound path.
- Holds a frame start and end address and steps a word address on each fetch request, in mono (+1) or stereo (+2) mode.
- Detects frame end, raises a one-cycle frame interrupt and either stops or reloads for looped playback.
- Counts completed frames.
- Sits between the sound register file (sfb/sfe, mode bits) and the sound FIFO fetch logic (adv).

Parameters:
AW, 21, address width; address bus bits are [AW:1] (word addressing).
LCW, 8, width of the completed-frame counter.

Ports:
sndclk  in  1  clock; all state changes on rising edge.
porb  in  1  asynchronous active-low reset.
lresb  in  1  synchronous active-low soft reset; highest priority after porb.
sfb  in  AW [AW:1]  frame start address.
sfe  in  AW [AW:1]  frame end address, exclusive.
play  in  1  playback enable (level).
loop  in  1  repeat mode (level).
dbl  in  1  stereo step: 1 = +2 words per adv, 0 = +1.
adv  in  1  one fetch done; advance the address.
snd  out  AW [AW:1]  current fetch address.
active  out  1  high while in PLAY.
sint  out  1  one-cycle frame-end pulse.
lcnt  out  LCW  completed-frame count; wraps modulo 2^LCW.

Behaviour:
- Reset: porb=0 forces, asynchronously, state=IDLE, snd=0, end register=0, active=0, sint=0, lcnt=0.
- lresb=0 at a clock edge has the same effect synchronously. It overrides play, adv and loop.
- States:
  - IDLE (active=0).
  - PLAY (active=1).
- IDLE:
  - play=1 and sfe>sfb (unsigned): snd<=sfb, end register<=sfe, go to PLAY. active=1 from the next cycle.
  - play=1 and sfe<=sfb (degenerate frame): stay in IDLE. snd, sint and lcnt are unchanged. Re-evaluate every cycle.
  - adv is ignored in IDLE. snd holds its last value.
- PLAY, play=0: go to IDLE next cycle. snd holds, no sint, lcnt unchanged. This takes priority over a same-cycle adv.
- PLAY, play=1, adv=1:
  - Compute nxt = snd + (dbl?2:1) in AW+1 bits. The carry counts as part of the value.
  - nxt < end register: snd<=nxt[AW-1:0].
  - nxt >= end register (frame end): sint=1 for exactly the next cycle and lcnt<=lcnt+1.
    - loop=1: snd<=sfb and end register<=sfe, re-sampled at this edge (double buffering, so software may rewrite sfb/sfe mid-frame). Stay in PLAY. If the new sfe<=sfb, go to IDLE instead.
    - loop=0: snd<=nxt[AW-1:0], go to IDLE.
- PLAY, adv=0: snd holds. sfb/sfe changes have no effect until the next load.
- Latency: snd reflects an adv one cycle later. sint is registered and coincides with the updated snd.
- Overrun: with dbl=1, end-start odd, snd may step past end-1. The frame ends on the first nxt>=end.
- Address wrap: snd=2^AW-1 (or -2 with dbl) plus step carries into bit AW. That always counts as >= end and ends the frame; no silent wrap to 0.
- Mode change: dbl is sampled per adv, so a mid-frame change takes effect on the next adv.
- lcnt wraps from 2^LCW-1 to 0 without a flag.

Test Plan:
- Reset and start:
  - porb low mid-PLAY → snd=0, active=0, lcnt=0 immediately.
  - Release, sfb=0x100, sfe=0x104, play=1 → next cycle snd=0x100, active=1.
- Mono one-shot: loop=0, dbl=0, 4 adv pulses → snd 0x101, 0x102, 0x103, then 0x104. sint=1 for one cycle with the fourth update, active=0, lcnt=1. Further adv leave snd=0x104.
- Looped stereo with rewrite:
  - loop=1, dbl=1, sfb=0x200, sfe=0x206.
  - Change to sfb=0x300, sfe=0x302 after the first adv.
  - Expected: snd 0x202, 0x204, then 0x300 with sint=1. Next adv → sint, snd=0x300 again, lcnt=2.
- Degenerate and abort:
  - sfe=sfb=0x50, play=1 → stays IDLE, no sint.
  - Separately, play drops in PLAY together with adv → IDLE, snd unchanged, no sint.
- Top-of-memory carry: AW=21, sfb=0x1FFFFE, sfe=0x1FFFFF, dbl=1, one adv → sint=1, IDLE, snd=0x000000 (nxt[AW-1:0]), no further stepping.
- Soft reset priority: lresb=0 in the same cycle as the frame-end adv → snd=0, no sint, lcnt unchanged at 0, IDLE.

Source files
------------

// File: rtl/snd_dma_frame_cnt.sv
// snd_dma_frame_cnt: sound-DMA frame address generator.
// Steps a word address per fetch, flags frame end, counts frames.
//
// Ports:
//   sndclk  clock
//   porb    asynchronous active-low reset
//   lresb   synchronous active-low soft reset
//   sfb     frame start address [AW:1]
//   sfe     frame end address, exclusive [AW:1]
//   play    playback enable (level)
//   loop    reload on frame end instead of stopping
//   dbl     stereo step (+2 words) when high, else +1
//   adv     one fetch completed; advance the address
//   snd     current fetch address [AW:1]
//   active  high while playing
//   sint    one-cycle frame-end pulse
//   lcnt    completed-frame count, wraps silently
module snd_dma_frame_cnt #(
    parameter int AW  = 21,
    parameter int LCW = 8
) (
    input  logic          sndclk,
    input  logic          porb,
    input  logic          lresb,
    input  logic [AW:1]   sfb,
    input  logic [AW:1]   sfe,
    input  logic          play,
    input  logic          loop,
    input  logic          dbl,
    input  logic          adv,
    output logic [AW:1]   snd,
    output logic          active,
    output logic          sint,
    output logic [LCW-1:0] lcnt
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t        state;
    logic [AW:1]   end_r;
    logic [AW:0]   nxt;
    logic [AW:0]   step;
    logic          frame_ok;

    // One extra bit keeps the carry out of the top address, so a
    // step past the top of memory always reads as >= end.
    assign step     = dbl ? (AW+1)'(2) : (AW+1)'(1);
    assign nxt      = {1'b0, snd} + step;
    assign frame_ok = (sfe > sfb);

    always_ff @(posedge sndclk or negedge porb) begin
        if (!porb) begin
            state  <= IDLE;
            snd    <= '0;
            end_r  <= '0;
            active <= 1'b0;
            sint   <= 1'b0;
            lcnt   <= '0;
        end else if (!lresb) begin
            state  <= IDLE;
            snd    <= '0;
            end_r  <= '0;
            active <= 1'b0;
            sint   <= 1'b0;
            lcnt   <= '0;
        end else begin
            sint <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Degenerate frames are refused; retried every cycle.
                    if (play && frame_ok) begin
                        snd    <= sfb;
                        end_r  <= sfe;
                        state  <= PLAY;
                        active <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!play) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else if (adv) begin
                        if (nxt < {1'b0, end_r}) begin
                            snd <= nxt[AW-1:0];
                        end else begin
                            sint <= 1'b1;
                            lcnt <= lcnt + LCW'(1);
                            if (loop) begin
                                // Bounds are re-sampled here so software
                                // can queue the next frame mid-play.
                                snd   <= sfb;
                                end_r <= sfe;
                                if (!frame_ok) begin
                                    state  <= IDLE;
                                    active <= 1'b0;
                                end
                            end else begin
                                snd    <= nxt[AW-1:0];
                                state  <= IDLE;
                                active <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
